wb_host_master: RTL

Wishbone classic single-transfer initiator for the user area: the master-side counterpart to the user project's Wishbone slave port. It accepts one command at a time over a valid/ready handshake and runs a single read or write cycle on a Wishbone bus. It then returns the read data, or a timeout error, over a valid/ready response channel. The intended use is driving a user-area Wishbone slave from logic-analyzer or IO-sourced commands during bring-up.

---
 rtl/wb_host_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_host_master.sv
// wb_host_master: single-transfer Wishbone classic initiator.
// Takes one command over a valid/ready handshake and runs one read or write
// cycle on the bus. Returns read data, zero for a write, or a timeout error
// over a valid/ready response channel. Every output comes straight from a flop.

module wb_host_master #(
    parameter int TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    // The counter only has to reach TIMEOUT-1, so it can never wrap.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cmd_take;
    logic [31:0]   w_rsp_dat_nxt;
    logic          w_rsp_err_nxt;

    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_cyc;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_dat;
    logic          r_rsp_err;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;

    // Next-state, timeout counter and response capture for the transfer FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cmd_take    = 1'b0;
        w_rsp_dat_nxt = r_rsp_dat;
        w_rsp_err_nxt = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_cmd_take  = 1'b1;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = ST_BUS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins over a simultaneous expiry.
                if (wbm_ack_i) begin
                    w_rsp_dat_nxt = r_we ? 32'h0000_0000 : wbm_dat_i;
                    w_rsp_err_nxt = 1'b0;
                    w_state_nxt   = ST_RESP;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_rsp_dat_nxt = 32'hFFFF_FFFF;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, command latch, response and output flags decoded from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= 32'h0000_0000;
            r_dat       <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_cyc       <= (w_state_nxt == ST_BUS);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_cmd_take) begin
                r_we  <= cmd_we_i;
                r_sel <= cmd_sel_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
            end else begin
                r_we  <= r_we;
                r_sel <= r_sel;
                r_adr <= r_adr;
                r_dat <= r_dat;
            end
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = r_busy;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;

endmodule
